// File: rtl/pc_pkg.sv
// Shared types, default widths and helpers for the program-counter unit.
package pc_pkg;

  localparam int unsigned PC_ADDR_W = 16;
  localparam int unsigned PC_DISP_W = 8;
  localparam int unsigned PC_MAX_W  = 64;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_BR   = 3'd2,
    PC_JMP  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_src_e;

  // Sign-extend the low 'width' bits of val to PC_MAX_W bits.
  function automatic logic [PC_MAX_W-1:0] sext(input logic [PC_MAX_W-1:0] val,
                                               input int unsigned width);
    logic signed [PC_MAX_W-1:0] tmp;
    int unsigned sh;
    sh  = PC_MAX_W - width;
    tmp = $signed(val << sh);
    return $unsigned(tmp >>> sh);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           ovf_c,
  output logic                           unf_c
);

  localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign top_ptr     = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
  assign wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
  assign do_pop      = pop & ~empty;
  assign do_push     = push & ~pop;
  assign ovf_c       = do_push & full;
  assign unf_c       = pop & empty;
  assign top         = mem[top_ptr];

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_pop) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
    end else if (do_push) begin
      wr_ptr <= wr_ptr_next;
      if (!full) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch, jump and call/return.
// Define PC_RAS_EN to build the return-address stack; otherwise call acts as jump and return as increment.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = PC_ADDR_W,
  parameter int unsigned       DISP_W     = PC_DISP_W,
  parameter int unsigned       RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           pc_en,
  input  logic                           br_en,
  input  logic [DISP_W-1:0]              disp,
  input  logic                           j_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic [ADDR_W-1:0]              dest,
  input  logic                           err_clr,
  output logic [ADDR_W-1:0]              addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  pc_src_e           src;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_br;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] addr_next;

  assign addr_inc = addr + ADDR_W'(1);
  assign addr_br  = addr + ADDR_W'(sext(PC_MAX_W'(disp), DISP_W));

  // Fixed-priority source select; a stall overrides every request.
  always_comb begin
    src = PC_HOLD;
    if (pc_en) begin
      if (ret_en)       src = PC_RET;
      else if (call_en) src = PC_CALL;
      else if (j_en)    src = PC_JMP;
      else if (br_en)   src = PC_BR;
      else              src = PC_INC;
    end
  end

  always_comb begin
    addr_next = addr;
    case (src)
      PC_HOLD:         addr_next = addr;
      PC_INC:          addr_next = addr_inc;
      PC_BR:           addr_next = addr_br;
      PC_JMP, PC_CALL: addr_next = dest;
      PC_RET:          addr_next = ret_addr;
      default:         addr_next = addr;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) addr <= RESET_ADDR;
    else        addr <= addr_next;
  end

`ifdef PC_RAS_EN
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_top;
  logic              ras_push;
  logic              ras_pop;
  logic              ovf_evt;
  logic              unf_evt;

  assign ras_push  = (src == PC_CALL);
  assign ras_pop   = (src == PC_RET);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  // Return on an empty stack falls through to the next sequential address.
  assign ret_addr  = ras_empty ? addr_inc : ras_top;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (addr_inc),
    .top       (ras_top),
    .count     (ras_count),
    .ovf_c     (ovf_evt),
    .unf_c     (unf_evt)
  );

  // Sticky error flags: a new event on the clearing edge wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (pc_en) begin
      ras_ovf <= (ras_ovf & ~err_clr) | ovf_evt;
      ras_unf <= (ras_unf & ~err_clr) | unf_evt;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign ret_addr       = addr_inc;
  assign ras_count      = '0;
  assign ras_empty      = 1'b1;
  assign ras_full       = 1'b0;
  assign ras_ovf        = 1'b0;
  assign ras_unf        = 1'b0;
`endif

endmodule
